// File: rtl/avg_window_scheduler_if.sv
// Sample/result bus of avg_window_scheduler: two valid/ready sensor channels,
// per-channel enables and the registered result strobe.
interface avg_window_scheduler_if #(
    parameter int N = 32
);
    localparam int CW = $clog2(N) + 1;

    logic [1:0]    ch_en;
    logic [15:0]   s0_data;
    logic          s0_valid;
    logic          s0_ready;
    logic [15:0]   s1_data;
    logic          s1_valid;
    logic          s1_ready;
    logic          res_valid;
    logic          res_ch;
    logic [CW-1:0] res_count;
    logic          res_major;
    logic          busy;

    // Sensor front-ends and paddle logic side.
    modport master (
        output ch_en, s0_data, s0_valid, s1_data, s1_valid,
        input  s0_ready, s1_ready, res_valid, res_ch, res_count, res_major, busy
    );

    // Scheduler side.
    modport slave (
        input  ch_en, s0_data, s0_valid, s1_data, s1_valid,
        output s0_ready, s1_ready, res_valid, res_ch, res_count, res_major, busy
    );
endinterface

// File: rtl/avg_window_scheduler.sv
// Two-channel round-robin sign-count window averager sharing one datapath.
// Define AVG_HYST_EN to give res_major per-channel hysteresis (3N/4 set, N/4 clear).
module avg_window_scheduler #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    avg_window_scheduler_if.slave bus
);
    localparam int CW = $clog2(N) + 1;
    localparam int NW = $clog2(N);
    localparam logic [NW-1:0] CNT_LAST = NW'(N - 1);
`ifdef AVG_HYST_EN
    localparam logic [CW-1:0] HYST_HI = CW'((3 * N) / 4);
    localparam logic [CW-1:0] HYST_LO = CW'(N / 4);
`endif

    typedef enum logic [1:0] {IDLE, ACCEPT, UPDATE, PUBLISH} state_t;

    state_t        state, state_d;
    logic          gnt, gnt_d;
    logic          rr;
    logic          sample_pos;
    logic [CW-1:0] acc [2];
    logic [NW-1:0] cnt [2];
`ifdef AVG_HYST_EN
    logic [1:0]    hyst;
`endif

    logic [1:0]    elig;
    logic [1:0]    ready_d;
    logic          gnt_valid;
    logic          gnt_bit15;
    logic          last;
    logic [CW-1:0] acc_upd;
    logic          major_d;

    logic [1:0]    ready_q;
    logic          res_valid_q;
    logic          res_ch_q;
    logic [CW-1:0] res_count_q;
    logic          res_major_q;
    logic          busy_q;

    assign elig      = bus.ch_en & {bus.s1_valid, bus.s0_valid};
    assign gnt_valid = gnt ? bus.s1_valid : bus.s0_valid;
    assign gnt_bit15 = gnt ? bus.s1_data[15] : bus.s0_data[15];
    assign last      = (cnt[gnt] == CNT_LAST);
    assign acc_upd   = acc[gnt] + CW'(sample_pos);

`ifdef AVG_HYST_EN
    always_comb begin
        major_d = hyst[gnt];
        if (acc_upd >= HYST_HI)
            major_d = 1'b1;
        else if (acc_upd <= HYST_LO)
            major_d = 1'b0;
    end
`else
    // Strict majority: a tie (acc == N/2) reports 0.
    assign major_d = ({acc_upd, 1'b0} > (CW + 1)'(N));
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state;
        gnt_d   = gnt;
        ready_d = 2'b00;
        case (state)
            IDLE: begin
                if (elig != 2'b00) begin
                    gnt_d   = (elig == 2'b11) ? ~rr : elig[1];
                    state_d = ACCEPT;
                end
            end
            ACCEPT:  state_d = gnt_valid ? UPDATE : IDLE;
            UPDATE:  state_d = last ? PUBLISH : IDLE;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == ACCEPT)
            ready_d = gnt_d ? 2'b10 : 2'b01;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= 1'b0;
        end else begin
            state <= state_d;
            gnt   <= gnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr          <= 1'b0;
            sample_pos  <= 1'b0;
            // NOTE: the per-channel window arrays are tiny flop banks and must start clean, so they are reset.
            for (int c = 0; c < 2; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
`ifdef AVG_HYST_EN
            hyst        <= 2'b00;
`endif
            ready_q     <= 2'b00;
            res_valid_q <= 1'b0;
            res_ch_q    <= 1'b0;
            res_count_q <= '0;
            res_major_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            busy_q      <= (state_d != IDLE);
            res_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    for (int c = 0; c < 2; c++) begin
                        if (!bus.ch_en[c]) begin
                            acc[c] <= '0;
                            cnt[c] <= '0;
                        end
                    end
                end
                ACCEPT: begin
                    if (gnt_valid) begin
                        sample_pos <= ~gnt_bit15;
                        rr         <= gnt;
                    end
                end
                UPDATE: begin
                    acc[gnt] <= acc_upd;
                    // Results load on entry to PUBLISH so res_valid lands two cycles after the accept.
                    if (last) begin
                        res_valid_q <= 1'b1;
                        res_ch_q    <= gnt;
                        res_count_q <= acc_upd;
                        res_major_q <= major_d;
`ifdef AVG_HYST_EN
                        hyst[gnt]   <= major_d;
`endif
                    end else begin
                        cnt[gnt] <= cnt[gnt] + 1'b1;
                    end
                end
                PUBLISH: begin
                    acc[gnt] <= '0;
                    cnt[gnt] <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.s0_ready  = ready_q[0];
    assign bus.s1_ready  = ready_q[1];
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_count = res_count_q;
    assign bus.res_major = res_major_q;
    assign bus.busy      = busy_q;
endmodule
